// File: rtl/mm_matrix_responder.sv
// Memory-side responder for the matrix-multiply engine: holds sizes, A and B,
// answers engine reads combinationally and captures result matrix C.
`timescale 1ns/1ps
module mm_matrix_responder #(
    parameter int N       = 20,
    parameter int MAX_DIM = 4,
    parameter int CW      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [N-1:0]     load_row,
    input  logic [N-1:0]     load_col,
    input  logic [N-1:0]     load_data,
    input  logic             start,
    input  logic [N-1:0]     c_row,
    input  logic [N-1:0]     c_col,
    output logic [2*N-1:0]   c_data,
    output logic             mm_rst,
    input  logic [N-1:0]     i,
    input  logic [N-1:0]     j,
    input  logic             read,
    input  logic             write,
    input  logic             index,
    input  logic [2*N-1:0]   write_data,
    input  logic             finish,
    output logic [N-1:0]     read_data,
    output logic             done,
    output logic             err,
    output logic [CW-1:0]    cycles,
    output logic [CW-1:0]    wr_count
);

    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [N-1:0] MAXD = N'(MAX_DIM);
    localparam logic [N-1:0] NSZ  = N'(3);

    typedef enum logic [1:0] {S_LOAD, S_ARM, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    logic          err_q, err_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [CW-1:0] wr_q, wr_d;

    logic [N-1:0]   a_mem [DEPTH];
    logic [N-1:0]   b_mem [DEPTH];
    logic [2*N-1:0] c_mem [DEPTH];

    logic a_we, b_we, c_we, c_clr;
    logic ld_ok, ld_in;

    // Range checks happen on full-width indices before this truncation.
    function automatic logic [AW-1:0] addr(input logic [N-1:0] r,
                                           input logic [N-1:0] c);
        logic [N-1:0] t;
        t = r * MAXD + c;
        return t[AW-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        err_d    = err_q;
        cycles_d = cycles_q;
        wr_d     = wr_q;
        a_we     = 1'b0;
        b_we     = 1'b0;
        c_we     = 1'b0;
        c_clr    = 1'b0;
        ld_ok    = (state_q == S_LOAD) || (state_q == S_DONE);
        ld_in    = (load_row < MAXD) && (load_col < MAXD);

        if (load_en && !ld_ok)
            err_d = 1'b1;

        if (load_en && ld_ok) begin
            case (load_sel)
                2'd0: begin
                    if (load_row < NSZ) begin
                        if (load_data == '0 || load_data > MAXD) begin
                            err_d = 1'b1;
                        end else begin
                            case (load_row[1:0])
                                2'd0:    s0_d = load_data;
                                2'd1:    s1_d = load_data;
                                default: s2_d = load_data;
                            endcase
                        end
                    end
                end
                2'd1:    a_we = ld_in;
                2'd2:    b_we = ld_in;
                default: ;
            endcase
        end

        case (state_q)
            S_LOAD: if (start) state_d = S_ARM;
            S_ARM: begin
                cycles_d = '0;
                wr_d     = '0;
                c_clr    = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (cycles_q != '1)
                    cycles_d = cycles_q + CW'(1);
                if (!read && write) begin
                    if (i < s0_q && j < s2_q) begin
                        c_we = 1'b1;
                        wr_d = wr_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (finish) state_d = S_DONE;
            end
            S_DONE: if (start) state_d = S_ARM;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LOAD;
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
            wr_q     <= '0;
        end else begin
            state_q  <= state_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
            wr_q     <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (a_we) a_mem[addr(load_row, load_col)] <= load_data;
        if (b_we) b_mem[addr(load_row, load_col)] <= load_data;
        if (c_clr)
            c_mem <= '{default: '0};
        else if (c_we)
            c_mem[addr(i, j)] <= write_data;
    end

    // Engine samples read_data in the same cycle it drives i/j.
    always_comb begin
        read_data = '0;
        if (read && write) begin
            case (i)
                N'(0):   read_data = s0_q;
                N'(1):   read_data = s1_q;
                N'(2):   read_data = s2_q;
                default: read_data = '0;
            endcase
        end else if (read && !index) begin
            if (i < s0_q && j < s1_q)
                read_data = a_mem[addr(i, j)];
        end else if (read) begin
            if (i < s1_q && j < s2_q)
                read_data = b_mem[addr(i, j)];
        end
    end

    always_comb begin
        c_data = '0;
        if (c_row < s0_q && c_col < s2_q)
            c_data = c_mem[addr(c_row, c_col)];
    end

    assign mm_rst   = (state_q != S_RUN);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign cycles   = cycles_q;
    assign wr_count = wr_q;

endmodule

// File: tb/tb_mm_matrix_responder.sv
// Bench for mm_matrix_responder: host loads, a behavioural MM engine,
// and a queue of expected C values checked on readback.
`timescale 1ns/1ps
module tb_mm_matrix_responder;

    localparam int N  = 20;
    localparam int MD = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            load_en;
    logic [1:0]      load_sel;
    logic [N-1:0]    load_row, load_col, load_data;
    logic            start;
    logic [N-1:0]    c_row, c_col;
    logic [2*N-1:0]  c_data;
    logic            mm_rst;
    logic [N-1:0]    i, j;
    logic            read, write, index;
    logic [2*N-1:0]  write_data;
    logic            finish;
    logic [N-1:0]    read_data;
    logic            done, err;
    logic [CW-1:0]   cycles, wr_count;

    mm_matrix_responder #(.N(N), .MAX_DIM(MD), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_sel(load_sel),
        .load_row(load_row), .load_col(load_col), .load_data(load_data),
        .start(start), .c_row(c_row), .c_col(c_col), .c_data(c_data),
        .mm_rst(mm_rst), .i(i), .j(j), .read(read), .write(write),
        .index(index), .write_data(write_data), .finish(finish),
        .read_data(read_data), .done(done), .err(err),
        .cycles(cycles), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [2*N-1:0] exp_q[$];
    int gs[3];
    int ga[MD][MD];
    int gb[MD][MD];
    logic [N-1:0] eng_rd;
    int acts;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_engine();
        read = 0; write = 0; index = 0; i = '0; j = '0;
        write_data = '0; finish = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] sel, input int r, input int c,
                        input logic [N-1:0] d);
        @(negedge clk);
        load_en = 1; load_sel = sel; load_row = N'(r); load_col = N'(c);
        load_data = d;
        @(negedge clk);
        load_en = 0;
    endtask

    task automatic load_all();
        for (int k = 0; k < 3; k++) load(2'd0, k, 0, N'(gs[k]));
        for (int r = 0; r < gs[0]; r++)
            for (int c = 0; c < gs[1]; c++) load(2'd1, r, c, N'(ga[r][c]));
        for (int r = 0; r < gs[1]; r++)
            for (int c = 0; c < gs[2]; c++) load(2'd2, r, c, N'(gb[r][c]));
    endtask

    task automatic sz_read(input int k, input logic [N-1:0] e);
        @(negedge clk);
        read = 1; write = 1; i = N'(k);
        exp_q.push_back({{N{1'b0}}, e});
        #1 check("sz_rd", {{N{1'b0}}, read_data}, exp_q.pop_front());
        read = 0; write = 0; i = '0;
    endtask

    task automatic push_c();
        int sum;
        for (int r = 0; r < gs[0]; r++)
            for (int c = 0; c < gs[2]; c++) begin
                sum = 0;
                for (int k = 0; k < gs[1]; k++) sum += ga[r][k] * gb[k][c];
                exp_q.push_back({{(2*N-32){sum[31]}}, sum});
            end
    endtask

    task automatic readback_c();
        @(negedge clk);
        for (int r = 0; r < gs[0]; r++)
            for (int c = 0; c < gs[2]; c++) begin
                c_row = N'(r); c_col = N'(c);
                #1 check("c_rd", c_data, exp_q.pop_front());
            end
        c_row = N'(gs[0]); c_col = '0;
        #1 check("c_oor", c_data, 0);
        c_row = '0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic eng(input logic r, input logic w, input logic x,
                       input int ii, input int jj,
                       input logic [2*N-1:0] wd, input logic f);
        read = r; write = w; index = x; i = N'(ii); j = N'(jj);
        write_data = wd; finish = f;
        acts++;
        #1 eng_rd = read_data;
        @(negedge clk);
    endtask

    task automatic run_engine(input bit bad_wr, input bit fin_w);
        int t;
        int m[3];
        logic signed [2*N-1:0] acc, ea, eb;
        bit last;
        t = 0;
        while (mm_rst && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("run_entry", mm_rst, 0);
        if (mm_rst) return;
        acts = 0;
        for (int k = 0; k < 3; k++) begin
            eng(1, 1, 0, k, 0, '0, 0);
            m[k] = (eng_rd > N'(MD)) ? MD : int'(eng_rd);
        end
        for (int r = 0; r < m[0]; r++)
            for (int c = 0; c < m[2]; c++) begin
                acc = '0;
                for (int k = 0; k < m[1]; k++) begin
                    eng(1, 0, 0, r, k, '0, 0);
                    ea = {{N{eng_rd[N-1]}}, eng_rd};
                    eng(1, 0, 1, k, c, '0, 0);
                    eb = {{N{eng_rd[N-1]}}, eng_rd};
                    acc = acc + ea * eb;
                end
                last = (r == m[0] - 1) && (c == m[2] - 1);
                eng(0, 1, 0, r, c, acc, fin_w && last);
            end
        if (!fin_w) begin
            eng(1, 0, 0, m[0], 0, '0, 0);
            check("eng_oor_rd", {{N{1'b0}}, eng_rd}, 0);
            if (bad_wr) eng(0, 1, 0, m[0], 0, 40'h12345, 0);
            eng(0, 0, 0, 0, 0, '0, 1);
        end
        idle_engine();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done", done, 1);
    endtask

    initial begin
        reset = 1; load_en = 0; load_sel = '0; load_row = '0;
        load_col = '0; load_data = '0; start = 0; c_row = '0; c_col = '0;
        idle_engine();
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_mm_rst", mm_rst, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cycles", cycles, 0);
        check("rst_wr", wr_count, 0);
        sz_read(0, '0);

        load(2'd0, 0, 0, '0);
        sz_read(0, '0);
        check("badld_err", err, 1);

        do_reset();
        check("rst2_err", err, 0);
        gs = '{2, 3, 2};
        ga[0][0] = 1; ga[0][1] = 2; ga[0][2] = 3;
        ga[1][0] = 4; ga[1][1] = 5; ga[1][2] = 6;
        gb[0][0] = 7;  gb[0][1] = 8;
        gb[1][0] = 9;  gb[1][1] = 10;
        gb[2][0] = 11; gb[2][1] = 12;
        load_all();
        sz_read(0, 20'd2);
        sz_read(1, 20'd3);
        sz_read(2, 20'd2);
        sz_read(3, 20'd0);

        @(negedge clk);
        read = 1; index = 0; i = 20'd2; j = '0;
        #1 check("host_oor_rd", read_data, 0);
        i = 20'd1; j = 20'd2;
        #1 check("a_rd", read_data, 6);
        index = 1; i = 20'd2; j = 20'd1;
        #1 check("b_rd", read_data, 12);
        idle_engine();
        check("oor_rd_err", err, 0);

        push_c();
        start_pulse();
        run_engine(0, 0);
        wait_done();
        check("run1_mm_rst", mm_rst, 1);
        check("run1_wr", wr_count, 4);
        check("run1_cyc", cycles, 64'(acts));
        check("run1_err", err, 0);
        readback_c();

        push_c();
        start_pulse();
        @(negedge clk);
        c_row = '0; c_col = '0;
        #1 check("rerun_clr", c_data, 0);
        check("rerun_done", done, 0);
        run_engine(0, 0);
        wait_done();
        check("run2_wr", wr_count, 4);
        check("run2_cyc", cycles, 64'(acts));
        readback_c();

        push_c();
        start_pulse();
        run_engine(1, 0);
        wait_done();
        check("badwr_err", err, 1);
        check("badwr_wr", wr_count, 4);
        readback_c();

        do_reset();
        gs = '{1, 1, 1};
        ga[0][0] = -3;
        gb[0][0] = 5;
        load_all();
        push_c();
        start_pulse();
        run_engine(0, 1);
        wait_done();
        check("sgn_cyc", cycles, 64'(acts));
        check("sgn_wr", wr_count, 1);
        readback_c();

        start_pulse();
        begin
            int t;
            t = 0;
            while (mm_rst && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        check("mid_run", mm_rst, 0);
        repeat (3) @(negedge clk);
        check("mid_cyc", cycles, 3);
        #2 reset = 1;
        #1;
        check("arst_mm_rst", mm_rst, 1);
        check("arst_done", done, 0);
        check("arst_cycles", cycles, 0);
        check("arst_wr", wr_count, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
